ecall_stream_ctrl: RTL and testbench

- Sequences the write-ecall byte stream from data memory (dual-port RAM, port B) to the Arduino parallel header.
- Replaces free-running offset counting with a four-phase strobe/ack handshake, so an external receiver at any speed gets every byte exactly once.
- Sits between the CPU's write-ecall signals, RAM port B and ARDUINO_IO[9:0].
- Reports completion back to the CPU as write_ecall_finished.

---
 rtl/ecall_stream_ctrl.sv | 159 +++++++++++++++
 tb/tb_ecall_stream_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ecall_stream_ctrl.sv
// Write-ecall byte streamer: RAM port B -> Arduino header with a four-phase strobe/ack
// handshake, so a receiver of any speed sees each byte exactly once.
module ecall_stream_ctrl #(
  parameter int DM_BITS     = 14,
  parameter int SETUP_CYC   = 2,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic               ADC_CLK_10,
  input  logic               rst,
  input  logic               start,
  input  logic [63:0]        base_addr,
  input  logic [63:0]        len,
  output logic               mem_rden,
  output logic [DM_BITS-1:0] mem_addr,
  input  logic [63:0]        mem_q,
  output logic [7:0]         tx_data,
  output logic               tx_strobe,
  input  logic               rx_ack,
  output logic               done,
  output logic               error,
  output logic [63:0]        bytes_sent
);
  localparam int SW = $clog2(SETUP_CYC + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_FETCH, S_CAPTURE, S_SETUP, S_WAIT_HI, S_WAIT_LO, S_FINISH
  } state_t;

  state_t             r_state;
  logic               r_start_d;
  logic               r_ack_m, r_ack_s;
  logic [63:0]        r_offset, r_bytes;
  logic [SW-1:0]      r_setup_cnt;
  logic [TW-1:0]      r_to_cnt;
  logic               r_mem_rden, r_strobe, r_done, r_error;
  logic [DM_BITS-1:0] r_mem_addr;
  logic [7:0]         r_tx_data;

  logic w_start_rise, w_busy, w_unused;

  assign w_start_rise = start & ~r_start_d;
  assign w_busy       = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign w_unused     = ^{base_addr[63:DM_BITS], mem_q[63:8]};

  assign mem_rden   = r_mem_rden;
  assign mem_addr   = r_mem_addr;
  assign tx_data    = r_tx_data;
  assign tx_strobe  = r_strobe;
  assign done       = r_done;
  assign error      = r_error;
  assign bytes_sent = r_bytes;

  // rx_ack comes from an unrelated receiver clock domain
  always_ff @(posedge ADC_CLK_10 or posedge rst) begin
    if (rst) begin
      r_ack_m <= 1'b0;
      r_ack_s <= 1'b0;
    end else begin
      r_ack_m <= rx_ack;
      r_ack_s <= r_ack_m;
    end
  end

  always_ff @(posedge ADC_CLK_10 or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_start_d   <= 1'b0;
      r_offset    <= '0;
      r_bytes     <= '0;
      r_setup_cnt <= '0;
      r_to_cnt    <= '0;
      r_mem_rden  <= 1'b0;
      r_mem_addr  <= '0;
      r_tx_data   <= '0;
      r_strobe    <= 1'b0;
      r_done      <= 1'b1;
      r_error     <= 1'b0;
    end else begin
      r_start_d  <= start;
      r_mem_rden <= 1'b0;
      if (w_busy && !start) begin
        // CPU withdrew the request: drop the strobe, keep error as is
        r_strobe <= 1'b0;
        r_done   <= 1'b1;
        r_state  <= S_FINISH;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start_rise) begin
              r_error  <= 1'b0;
              r_bytes  <= '0;
              r_offset <= '0;
              r_done   <= 1'b0;
              r_state  <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (r_offset >= len) begin
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_mem_rden <= 1'b1;
              r_mem_addr <= base_addr[DM_BITS-1:0] + r_offset[DM_BITS-1:0];
              r_state    <= S_FETCH;
            end
          end
          S_FETCH: r_state <= S_CAPTURE;
          S_CAPTURE: begin
            r_tx_data   <= mem_q[7:0];
            r_setup_cnt <= SW'(SETUP_CYC);
            r_state     <= S_SETUP;
          end
          S_SETUP: begin
            if (r_setup_cnt <= SW'(1)) begin
              r_strobe <= 1'b1;
              r_to_cnt <= TW'(ACK_TIMEOUT);
              r_state  <= S_WAIT_HI;
            end else begin
              r_setup_cnt <= r_setup_cnt - 1'b1;
            end
          end
          S_WAIT_HI: begin
            if (r_ack_s) begin
              r_strobe <= 1'b0;
              r_bytes  <= r_bytes + 64'd1;
              r_offset <= r_offset + 64'd1;
              r_to_cnt <= TW'(ACK_TIMEOUT);
              r_state  <= S_WAIT_LO;
            end else if (r_to_cnt <= TW'(1)) begin
              r_error  <= 1'b1;
              r_strobe <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_FINISH;
            end else begin
              r_to_cnt <= r_to_cnt - 1'b1;
            end
          end
          S_WAIT_LO: begin
            if (!r_ack_s) begin
              r_state <= S_CHECK;
            end else if (r_to_cnt <= TW'(1)) begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_to_cnt <= r_to_cnt - 1'b1;
            end
          end
          S_FINISH: begin
            r_strobe <= 1'b0;
            if (!start) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ecall_stream_ctrl.sv
// Bench for ecall_stream_ctrl: RAM model, random-latency receiver and a per-transfer
// reference model predicting bytes, addresses, counts and error outcome.
module tb_ecall_stream_ctrl;
  localparam int DM_BITS     = 14;
  localparam int SETUP_CYC   = 2;
  localparam int ACK_TIMEOUT = 16;
  localparam int DEPTH       = 1 << DM_BITS;

  logic               clk = 1'b0, rst = 1'b1, start = 1'b0, rx_ack = 1'b0;
  logic [63:0]        base_addr = '0, len = '0, mem_q = '0;
  logic               mem_rden, tx_strobe, done, error;
  logic [DM_BITS-1:0] mem_addr;
  logic [7:0]         tx_data;
  logic [63:0]        bytes_sent;

  logic [7:0]         ram [0:DEPTH-1];
  logic [DM_BITS-1:0] addr_q[$];
  logic [7:0]         byte_q[$];
  int checks = 0, errors = 0;
  int rx_limit = 1000, rx_dly = 3, rx_given = 0, rcnt = 0;
  int stab_err = 0, width = 0, last_width = 0;
  logic strobe_prev = 1'b0;
  logic [7:0] held = '0;

  always #5 clk = ~clk;

  ecall_stream_ctrl #(.DM_BITS(DM_BITS), .SETUP_CYC(SETUP_CYC), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .ADC_CLK_10(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .mem_rden(mem_rden), .mem_addr(mem_addr), .mem_q(mem_q), .tx_data(tx_data),
    .tx_strobe(tx_strobe), .rx_ack(rx_ack), .done(done), .error(error),
    .bytes_sent(bytes_sent)
  );

  // RAM port B: one-cycle registered read, junk in the unused upper bits
  always @(posedge clk) if (mem_rden) mem_q <= {56'hDEADBEEFCAFE12, ram[mem_addr]};

  // receiver: follows strobe after rx_dly cycles, stops acking after rx_limit bytes
  initial forever begin
    @(negedge clk);
    if (rst) begin
      rx_ack = 1'b0; rcnt = 0;
    end else if (tx_strobe !== rx_ack) begin
      if (!rx_ack && rx_given >= rx_limit) rcnt = 0;
      else if (rcnt >= rx_dly) begin
        rx_ack = ~rx_ack;
        if (rx_ack) rx_given++;
        rcnt = 0;
      end else rcnt++;
    end else rcnt = 0;
  end

  // monitor: reads issued, byte at each strobe rise, data stability, pulse width
  initial forever begin
    @(negedge clk);
    if (mem_rden) addr_q.push_back(mem_addr);
    if (tx_strobe && !strobe_prev) begin
      byte_q.push_back(tx_data);
      held  = tx_data;
      width = 0;
    end
    if (tx_strobe) begin
      width++;
      last_width = width;
      if (tx_data !== held) stab_err++;
    end
    strobe_prev = tx_strobe;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_xfer(input logic [63:0] b, input logic [63:0] l, input int limit,
                          input int dly, input bit fill, output int cyc);
    int n_exp;
    logic [63:0] exp_sent;
    logic [DM_BITS-1:0] a;
    addr_q.delete(); byte_q.delete();
    stab_err = 0; rx_given = 0; rx_limit = limit; rx_dly = dly;
    base_addr = b; len = l;
    if (fill)
      for (int i = 0; i < int'(l); i++) begin
        a = DM_BITS'(b + 64'(i));
        ram[a] = 8'($urandom);
      end
    start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin @(negedge clk); cyc++; end
    check("xfer_budget", 64'(cyc < 3000), 64'd1);
    // reference: every byte up to the first unacked one is strobed once
    if (64'(limit) >= l) begin n_exp = int'(l); exp_sent = l; end
    else begin n_exp = limit + 1; exp_sent = 64'(limit); end
    check("pulses", 64'(byte_q.size()), 64'(n_exp));
    check("reads", 64'(addr_q.size()), 64'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      a = DM_BITS'(b + 64'(i));
      if (i < byte_q.size()) check("byte", 64'(byte_q[i]), 64'(ram[a]));
      if (i < addr_q.size()) check("addr", 64'(addr_q[i]), 64'(a));
    end
    check("bytes_sent", bytes_sent, exp_sent);
    check("error", 64'(error), 64'(64'(limit) < l));
    check("stable", 64'(stab_err), 64'd0);
    check("done", 64'(done), 64'd1);
    check("strobe_off", 64'(tx_strobe), 64'd0);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    check("idle_done", 64'(done), 64'd1);
  endtask

  initial begin
    int cyc, lim, l, k;
    logic [63:0] b;
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'(i);

    repeat (3) @(negedge clk);
    check("rst_done", 64'(done), 64'd1);
    check("rst_error", 64'(error), 64'd0);
    check("rst_strobe", 64'(tx_strobe), 64'd0);
    check("rst_txdata", 64'(tx_data), 64'd0);
    check("rst_rden", 64'(mem_rden), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_bytes", bytes_sent, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed three-byte transfer
    ram[14'h100] = 8'h41; ram[14'h101] = 8'h42; ram[14'h102] = 8'h43;
    run_xfer(64'h100, 64'd3, 1000, 3, 1'b0, cyc);
    if (byte_q.size() == 3) check("abc", {40'd0, byte_q[0], byte_q[1], byte_q[2]}, 64'h414243);

    // empty transfer
    run_xfer(64'h200, 64'd0, 1000, 3, 1'b1, cyc);
    check("len0_latency", 64'(cyc <= 2), 64'd1);

    // address wrap at the top of data memory
    run_xfer(64'(DEPTH - 1), 64'd2, 1000, 1, 1'b1, cyc);
    if (addr_q.size() == 2) begin
      check("wrap_a0", 64'(addr_q[0]), 64'(DEPTH - 1));
      check("wrap_a1", 64'(addr_q[1]), 64'd0);
    end

    // receiver goes silent on byte 2
    run_xfer(64'h3000, 64'd4, 1, 2, 1'b1, cyc);
    check("to_width", 64'(last_width >= ACK_TIMEOUT - 1 && last_width <= ACK_TIMEOUT + 1), 64'd1);
    run_xfer(64'h3100, 64'd2, 1000, 0, 1'b1, cyc);

    // randomized transfers: random base (upper bits junk), length, latency, silence point
    for (int t = 0; t < 10; t++) begin
      b   = {$urandom, $urandom};
      if (t % 3 == 0) b[DM_BITS-1:0] = DM_BITS'(DEPTH - 1 - $urandom_range(0, 3));
      l   = $urandom_range(1, 6);
      lim = ($urandom_range(0, 3) == 0) ? $urandom_range(0, l - 1) : 1000;
      run_xfer(b, 64'(l), lim, $urandom_range(0, 5), 1'b1, cyc);
    end

    // abort while waiting for the first ack
    addr_q.delete(); byte_q.delete();
    rx_given = 0; rx_limit = 0; base_addr = 64'h40; len = 64'd5;
    start = 1'b1;
    k = 0;
    while (tx_strobe !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    check("abort_strobe_seen", 64'(tx_strobe), 64'd1);
    start = 1'b0;
    @(negedge clk);
    check("abort_strobe", 64'(tx_strobe), 64'd0);
    check("abort_done", 64'(done), 64'd1);
    @(negedge clk);
    check("abort_bytes", bytes_sent, 64'd0);
    check("abort_error", 64'(error), 64'd0);
    check("abort_idle", 64'(done), 64'd1);

    // asynchronous reset with the strobe up
    rx_given = 0; rx_limit = 1000; rx_dly = 3; base_addr = 64'h500; len = 64'd3;
    start = 1'b1;
    k = 0;
    while (tx_strobe !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    check("rst_strobe_seen", 64'(tx_strobe), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_strobe", 64'(tx_strobe), 64'd0);
    check("arst_txdata", 64'(tx_data), 64'd0);
    check("arst_done", 64'(done), 64'd1);
    check("arst_bytes", bytes_sent, 64'd0);
    check("arst_rden", 64'(mem_rden), 64'd0);
    check("arst_addr", 64'(mem_addr), 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_xfer(64'h600, 64'd1, 1000, 2, 1'b1, cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
